// File: rtl/mul_div_pkg.sv
// Shared definitions for the mul_div unit.
// Holds the divider op encodings, the default operand/tag widths and the
// per-request sideband record that travels alongside the divider cell chain.
package mul_div_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int TAG_W_DEFAULT = 5;

    // RISC-V divide-family operation encodings.
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    // Sideband captured at issue, at the default widths.
    typedef struct packed {
        div_op_e                  op;
        logic                     neg_q;
        logic                     neg_r;
        logic                     div0;
        logic                     ovf;
        logic [XLEN_DEFAULT-1:0]  dividend;
        logic [TAG_W_DEFAULT-1:0] tag;
    } div_sb_t;

endpackage

// File: rtl/div_result_stage_if.sv
// Issue and result handshake bundle of div_result_stage.
// master: requester/consumer side (drives issue_*, res_ready).
// slave : div_result_stage side (drives issue_ready, res_valid/data/tag).
interface div_result_stage_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) ();
    logic             issue_valid;
    logic             issue_ready;
    logic [1:0]       issue_op;
    logic             issue_neg_q;
    logic             issue_neg_r;
    logic             issue_div0;
    logic             issue_ovf;
    logic [XLEN-1:0]  issue_dividend;
    logic [TAG_W-1:0] issue_tag;
    logic             res_valid;
    logic             res_ready;
    logic [XLEN-1:0]  res_data;
    logic [TAG_W-1:0] res_tag;

    modport master (
        output issue_valid, issue_op, issue_neg_q, issue_neg_r, issue_div0,
               issue_ovf, issue_dividend, issue_tag, res_ready,
        input  issue_ready, res_valid, res_data, res_tag
    );

    modport slave (
        input  issue_valid, issue_op, issue_neg_q, issue_neg_r, issue_div0,
               issue_ovf, issue_dividend, issue_tag, res_ready,
        output issue_ready, res_valid, res_data, res_tag
    );
endinterface

// File: rtl/div_result_fifo.sv
// Synchronous DEPTH-entry result FIFO.
// Ports: clk/rstn (async active-low), flush (sync clear), push/push_data
// write side, pop_ready/rd_valid/rd_data read side, count (occupancy) and
// overflow (a push that found the FIFO full with no pop; data dropped).
module div_result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 37
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop_ready,
    output logic         rd_valid,
    output logic [W-1:0] rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic         overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic          valid_r;
    logic          full_s;
    logic          pop_s;
    logic          push_ok_s;

    assign full_s    = (count_r == CW'(DEPTH));
    assign pop_s     = pop_ready && valid_r && !flush;
    // A pop in the same cycle frees the slot, so a push at full is legal then.
    assign push_ok_s = push && !flush && (!full_s || pop_s);
    assign overflow  = push && !flush && full_s && !pop_s;

    assign rd_valid = valid_r;
    assign rd_data  = mem_r[rd_ptr_r];
    assign count    = count_r;

    // Next occupancy from the push/pop pair.
    always_comb begin
        count_next_s = count_r;
        if (flush) begin
            count_next_s = '0;
        end else begin
            case ({push_ok_s, pop_s})
                2'b10:   count_next_s = count_r + CW'(1);
                2'b01:   count_next_s = count_r - CW'(1);
                default: count_next_s = count_r;
            endcase
        end
    end

    // Occupancy, pointers and registered valid flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            valid_r  <= 1'b0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            valid_r  <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_next_s;
            valid_r <= (count_next_s != '0);
        end
    end

    // Storage; cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end
endmodule

// File: rtl/div_result_stage.sv
// Output stage of the pipelined divider.
// A LAT-deep sideband delay line runs beside the divider cell chain; when an
// entry leaves the last stage it meets cell_rdy and the magnitude results,
// the RISC-V DIV/DIVU/REM/REMU sign and special-case rules are applied, and
// the final value is queued in div_result_fifo towards writeback.
// Ports: clk, rstn (async active-low); bus (issue and result handshakes);
// cell_rdy/cell_merchant/cell_remainder from the last divider cell;
// flush (sync kill of everything in flight); sb_err (sticky misalignment).
module div_result_stage
    import mul_div_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int LAT   = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = TAG_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rstn,
    div_result_stage_if.slave bus,
    input  logic            cell_rdy,
    input  logic [XLEN-1:0] cell_merchant,
    input  logic [XLEN-1:0] cell_remainder,
    input  logic            flush,
    output logic            sb_err
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic             valid;
        div_op_e          op;
        logic             neg_q;
        logic             neg_r;
        logic             div0;
        logic             ovf;
        logic [XLEN-1:0]  dividend;
        logic [TAG_W-1:0] tag;
    } line_t;

    line_t            line_r [LAT];
    line_t            issue_entry_s;
    line_t            head_s;
    logic [CW-1:0]    inflight_r;
    logic [CW-1:0]    fifo_count_s;
    logic [CW:0]      credit_used_s;
    logic             fire_s;
    logic             arrive_s;
    logic             push_s;
    logic             overflow_s;
    logic [XLEN-1:0]  result_s;
    logic [XLEN+TAG_W-1:0] rd_word_s;

    function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] v);
        return ~v + XLEN'(1);
    endfunction

    // Credit: every in-flight request owns a FIFO slot, so the chain never
    // delivers into a full FIFO.
    assign credit_used_s   = {1'b0, inflight_r} + {1'b0, fifo_count_s};
    assign bus.issue_ready = (credit_used_s < (CW+1)'(DEPTH));
    assign fire_s          = bus.issue_valid && bus.issue_ready;
    assign head_s          = line_r[LAT-1];
    assign arrive_s        = head_s.valid;
    assign push_s          = arrive_s && !flush;

    // Sideband record entering stage 0.
    always_comb begin
        issue_entry_s          = '0;
        issue_entry_s.valid    = fire_s && !flush;
        issue_entry_s.op       = div_op_e'(bus.issue_op);
        issue_entry_s.neg_q    = bus.issue_neg_q;
        issue_entry_s.neg_r    = bus.issue_neg_r;
        issue_entry_s.div0     = bus.issue_div0;
        issue_entry_s.ovf      = bus.issue_ovf;
        issue_entry_s.dividend = bus.issue_dividend;
        issue_entry_s.tag      = bus.issue_tag;
    end

    // Sideband delay line; shifts every cycle, flush kills all valid bits.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LAT; i++) begin
                line_r[i] <= '0;
            end
        end else begin
            line_r[0] <= issue_entry_s;
            for (int i = 1; i < LAT; i++) begin
                line_r[i]       <= line_r[i-1];
                line_r[i].valid <= line_r[i-1].valid && !flush;
            end
        end
    end

    // Requests issued but not yet arrived at the chain output.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight_r <= '0;
        end else if (flush) begin
            inflight_r <= '0;
        end else begin
            case ({fire_s, arrive_s})
                2'b10:   inflight_r <= inflight_r + CW'(1);
                2'b01:   inflight_r <= inflight_r - CW'(1);
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    // Sign and special-case fixup; neg flags only matter for signed ops.
    always_comb begin
        result_s = '0;
        case (head_s.op)
            OP_DIV: begin
                if (head_s.div0) begin
                    result_s = '1;
                end else if (head_s.ovf) begin
                    result_s = head_s.dividend;
                end else if (head_s.neg_q) begin
                    result_s = twos_neg(cell_merchant);
                end else begin
                    result_s = cell_merchant;
                end
            end
            OP_DIVU: begin
                if (head_s.div0) begin
                    result_s = '1;
                end else begin
                    result_s = cell_merchant;
                end
            end
            OP_REM: begin
                if (head_s.div0) begin
                    result_s = head_s.dividend;
                end else if (head_s.ovf) begin
                    result_s = '0;
                end else if (head_s.neg_r) begin
                    result_s = twos_neg(cell_remainder);
                end else begin
                    result_s = cell_remainder;
                end
            end
            OP_REMU: begin
                if (head_s.div0) begin
                    result_s = head_s.dividend;
                end else begin
                    result_s = cell_remainder;
                end
            end
            default: result_s = '0;
        endcase
    end

    div_result_fifo #(
        .DEPTH (DEPTH),
        .W     (XLEN + TAG_W)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .push      (push_s),
        .push_data ({head_s.tag, result_s}),
        .pop_ready (bus.res_ready),
        .rd_valid  (bus.res_valid),
        .rd_data   (rd_word_s),
        .count     (fifo_count_s),
        .overflow  (overflow_s)
    );

    assign bus.res_data = rd_word_s[XLEN-1:0];
    assign bus.res_tag  = rd_word_s[XLEN+TAG_W-1:XLEN];

    // Sticky error: sideband arrived without cell_rdy, or a write hit a full FIFO.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sb_err <= 1'b0;
        end else if (!flush && ((arrive_s && !cell_rdy) || overflow_s)) begin
            sb_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_div_result_stage.sv
// Scoreboard bench for div_result_stage: a behavioural front end derives the
// sideband and magnitude cell results from operands, the expected RISC-V
// result is computed with plain signed/unsigned arithmetic, and a monitor
// compares every accepted output against the queue in order.
module tb_div_result_stage;
    import mul_div_pkg::*;

    localparam int XLEN  = 32;
    localparam int LAT   = 32;
    localparam int DEPTH = 4;
    localparam int TAG_W = 5;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cell_rdy;
    logic [31:0] cell_merchant;
    logic [31:0] cell_remainder;
    logic        flush;
    logic        sb_err;

    always #5 clk = ~clk;

    div_result_stage_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    div_result_stage #(.XLEN(XLEN), .LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .bus            (bus),
        .cell_rdy       (cell_rdy),
        .cell_merchant  (cell_merchant),
        .cell_remainder (cell_remainder),
        .flush          (flush),
        .sb_err         (sb_err)
    );

    typedef struct { logic [31:0] data; logic [4:0] tag; } exp_t;
    typedef struct { int due; logic rdy; logic [31:0] q; logic [31:0] r; } cell_t;

    exp_t  exp_q [$];
    cell_t cell_q [$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    nfire = 0;
    int    last_issue = 0;
    logic [7:0] tag_ctr = 8'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RISC-V divide semantics straight from the ISA rules.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            2'b00: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                else if (ovf) return a;
                else return $signed(a) / $signed(b);
            end
            2'b01: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                else return a / b;
            end
            2'b10: begin
                if (b == 32'd0) return a;
                else if (ovf) return 32'd0;
                else return $signed(a) % $signed(b);
            end
            default: begin
                if (b == 32'd0) return a;
                else return a % b;
            end
        endcase
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // One clock of stimulus; the front end computes sideband and cell outputs.
    task automatic drive_cycle(input bit want, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input bit drop, output bit fired);
        logic sgn, div0, ovf;
        logic [31:0] ma, mb, q, r;
        cell_t c;
        exp_t  e;
        @(posedge clk);
        #1;
        sgn  = ~op[0];
        div0 = (b == 32'd0);
        ovf  = sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        ma   = (sgn && a[31]) ? (~a + 32'd1) : a;
        mb   = (sgn && b[31]) ? (~b + 32'd1) : b;
        q    = div0 ? 32'hFFFF_FFFF : (ma / mb);
        r    = div0 ? ma : (ma % mb);
        bus.issue_valid    = want;
        bus.issue_op       = op;
        bus.issue_neg_q    = sgn ? (a[31] ^ b[31]) : 1'($urandom_range(0, 1));
        bus.issue_neg_r    = sgn ? a[31] : 1'($urandom_range(0, 1));
        bus.issue_div0     = div0;
        bus.issue_ovf      = ovf;
        bus.issue_dividend = a;
        bus.issue_tag      = tag_ctr[4:0];
        fired = want && bus.issue_ready;
        if (fired) begin
            e.data = ref_result(op, a, b);
            e.tag  = tag_ctr[4:0];
            exp_q.push_back(e);
            c.due = cyc + LAT;
            c.rdy = !drop;
            c.q   = q;
            c.r   = r;
            cell_q.push_back(c);
            tag_ctr++;
            nfire++;
            last_issue = cyc;
        end
    endtask

    task automatic idle();
        bit f;
        drive_cycle(1'b0, 2'b00, 32'd0, 32'd1, 1'b0, f);
    endtask

    task automatic issue_one(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             input bit drop);
        bit f;
        int n;
        f = 1'b0;
        n = 0;
        while (!f && n < 200) begin
            drive_cycle(1'b1, op, a, b, drop, f);
            n++;
        end
        if (!f) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: got no credit expected credit within 200 cycles");
        end
        idle();
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || cell_q.size() != 0) && n < 400) begin
            idle();
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
    endtask

    // Last divider cell: present each response exactly LAT cycles after issue.
    initial begin
        cell_rdy = 1'b0;
        cell_merchant = 32'd0;
        cell_remainder = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            cell_rdy = 1'b0;
            if (cell_q.size() != 0 && cell_q[0].due == cyc) begin
                cell_t c;
                c = cell_q.pop_front();
                cell_rdy       = c.rdy;
                cell_merchant  = c.q;
                cell_remainder = c.r;
            end else begin
                cell_merchant  = $urandom;
                cell_remainder = $urandom;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: in-order scoreboard plus hold-stability checks.
    initial begin
        logic        held;
        logic [31:0] held_data;
        logic [4:0]  held_tag;
        exp_t        e;
        held = 1'b0;
        held_data = 32'd0;
        held_tag = 5'd0;
        forever begin
            @(negedge clk);
            if (rstn && !flush) begin
                if (held) begin
                    check("hold_valid", {31'd0, bus.res_valid}, 32'd1);
                    check("hold_data", bus.res_data, held_data);
                    check("hold_tag", {27'd0, bus.res_tag}, {27'd0, held_tag});
                end
                if (bus.res_valid && bus.res_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_result: got tag %0d data %h expected none",
                                 bus.res_tag, bus.res_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("res_data", bus.res_data, e.data);
                        check("res_tag", {27'd0, bus.res_tag}, {27'd0, e.tag});
                    end
                end
                held      = bus.res_valid && !bus.res_ready;
                held_data = bus.res_data;
                held_tag  = bus.res_tag;
            end else begin
                held = 1'b0;
                if (flush) exp_q.delete();
            end
        end
    end

    initial begin
        #2_000_000;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int t;
        int nf0;
        bit f;
        bus.issue_valid = 1'b0;
        bus.issue_op = 2'b00;
        bus.issue_neg_q = 1'b0;
        bus.issue_neg_r = 1'b0;
        bus.issue_div0 = 1'b0;
        bus.issue_ovf = 1'b0;
        bus.issue_dividend = 32'd0;
        bus.issue_tag = 5'd0;
        bus.res_ready = 1'b1;
        flush = 1'b0;
        #1;
        check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        check("rst_res_data", bus.res_data, 32'd0);
        check("rst_res_tag", {27'd0, bus.res_tag}, 32'd0);
        check("rst_sb_err", {31'd0, sb_err}, 32'd0);
        check("rst_issue_ready", {31'd0, bus.issue_ready}, 32'd1);
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // Latency: DIVU 100/7 -> 14, visible exactly LAT+1 cycles after issue.
        issue_one(2'b01, 32'd100, 32'd7, 1'b0);
        t = last_issue;
        while (cyc < t + LAT) idle();
        check("lat_not_early", {31'd0, bus.res_valid}, 32'd0);
        idle();
        check("lat_valid", {31'd0, bus.res_valid}, 32'd1);
        check("lat_data", bus.res_data, 32'd14);
        check("lat_tag", {27'd0, bus.res_tag}, 32'd0);
        wait_drain();

        // Signed fixups and special cases.
        issue_one(2'b00, -32'sd100, 32'd7, 1'b0);
        issue_one(2'b10, -32'sd100, 32'd7, 1'b0);
        issue_one(2'b01, 32'hCAFE_0001, 32'd0, 1'b0);
        issue_one(2'b10, 32'h1234_5678, 32'd0, 1'b0);
        issue_one(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        issue_one(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_drain();

        // Back-pressure: exactly DEPTH accepted, results held stable in order.
        bus.res_ready = 1'b0;
        nf0 = nfire;
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b1, 2'($urandom_range(0, 3)), rand_operand(), rand_operand(), 1'b0, f);
        end
        check("full_fires", 32'(nfire - nf0), 32'(DEPTH));
        check("full_issue_ready", {31'd0, bus.issue_ready}, 32'd0);
        repeat (LAT + 4) idle();
        check("full_res_valid", {31'd0, bus.res_valid}, 32'd1);
        check("full_still_blocked", {31'd0, bus.issue_ready}, 32'd0);
        bus.res_ready = 1'b1;
        wait_drain();
        check("drain_issue_ready", {31'd0, bus.issue_ready}, 32'd1);

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 300; i++) begin
            drive_cycle(($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)),
                        rand_operand(), rand_operand(), 1'b0, f);
            bus.res_ready = ($urandom_range(0, 3) != 0);
        end
        bus.res_ready = 1'b1;
        wait_drain();
        check("sb_err_clean", {31'd0, sb_err}, 32'd0);

        // Flush with two buffered and two in flight.
        bus.res_ready = 1'b0;
        issue_one(2'b01, 32'd81, 32'd9, 1'b0);
        issue_one(2'b01, 32'd64, 32'd8, 1'b0);
        repeat (LAT + 2) idle();
        issue_one(2'b11, 32'd65, 32'd8, 1'b0);
        issue_one(2'b11, 32'd66, 32'd8, 1'b0);
        @(posedge clk);
        #1;
        bus.issue_valid = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_res_valid", {31'd0, bus.res_valid}, 32'd0);
        check("flush_issue_ready", {31'd0, bus.issue_ready}, 32'd1);
        bus.res_ready = 1'b1;
        repeat (LAT + 4) idle();
        check("flush_no_late", {31'd0, bus.res_valid}, 32'd0);
        bus.res_ready = 1'b0;
        nf0 = nfire;
        for (int i = 0; i < DEPTH; i++) begin
            drive_cycle(1'b1, 2'b01, 32'd200 + 32'(i), 32'd3, 1'b0, f);
        end
        check("flush_credit_back", 32'(nfire - nf0), 32'(DEPTH));
        bus.res_ready = 1'b1;
        wait_drain();
        check("flush_sb_err", {31'd0, sb_err}, 32'd0);

        // Misaligned arrival: result still written, sb_err sticks.
        issue_one(2'b01, 32'd50, 32'd5, 1'b1);
        wait_drain();
        check("misalign_sb_err", {31'd0, sb_err}, 32'd1);
        issue_one(2'b00, 32'd21, 32'd4, 1'b0);
        wait_drain();
        check("misalign_sticky", {31'd0, sb_err}, 32'd1);

        // Asynchronous reset in the middle of traffic.
        bus.res_ready = 1'b0;
        issue_one(2'b01, 32'd90, 32'd9, 1'b0);
        issue_one(2'b01, 32'd91, 32'd9, 1'b0);
        repeat (LAT + 2) idle();
        issue_one(2'b01, 32'd92, 32'd9, 1'b0);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        exp_q.delete();
        cell_q.delete();
        #1;
        check("arst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        check("arst_res_data", bus.res_data, 32'd0);
        check("arst_res_tag", {27'd0, bus.res_tag}, 32'd0);
        check("arst_sb_err", {31'd0, sb_err}, 32'd0);
        check("arst_issue_ready", {31'd0, bus.issue_ready}, 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        bus.res_ready = 1'b1;
        issue_one(2'b01, 32'd9, 32'd3, 1'b0);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
